channel_lut_host_bridge: RTL and testbench

Host-side initiator for the channel look-up-table configuration port of the channel selector. It accepts Wishbone classic single accesses from the host register bus and converts each one into a single write or read on the selector's request/acknowledge LUT port (`lut_WrRd`, `lut_addr`, data, `lut_ack`). It withholds LUT traffic until the selector reports that its reset sweep of the LUT has finished. It sits between the Wishbone interconnect and the combination front end, and exposes a small status register.

---
 rtl/channel_lut_host_bridge_if.sv | 24 ++
 rtl/channel_lut_host_bridge.sv | 137 +++++++++++++
 tb/tb_channel_lut_host_bridge.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/channel_lut_host_bridge_if.sv
// Wishbone classic slave bundle between the host register bus and the channel LUT bridge.
interface channel_lut_host_bridge_if #(
    parameter int CHANNEL_INP_WIDTH = 6,
    parameter int WB_DAT_WIDTH      = 32
);
    logic [CHANNEL_INP_WIDTH:0] wb_adr_i;
    logic [WB_DAT_WIDTH-1:0]    wb_dat_i;
    logic [WB_DAT_WIDTH-1:0]    wb_dat_o;
    logic                       wb_we_i;
    logic                       wb_stb_i;
    logic                       wb_cyc_i;
    logic                       wb_ack_o;
    logic                       wb_err_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/channel_lut_host_bridge.sv
// Wishbone-to-LUT request/ack bridge for the channel selector, gated by the selector's LUT clear.
// Optional acknowledge watchdog: define CHANNEL_LUT_TIMEOUT_EN.
//
// state     | meaning
// WAIT_INIT | selector LUT clear not yet reported; LUT accesses end in error
// IDLE      | initialised, waiting for a host strobe
// REQ       | lut_WrRd asserted, waiting for lut_ack
// RESP      | one-cycle ack/err to the host, strobe ignored
module channel_lut_host_bridge #(
    parameter int CHANNEL_INP_WIDTH  = 6,
    parameter int CHANNEL_OUTP_WIDTH = 4,
    parameter int WB_DAT_WIDTH       = 32,
    parameter int TIMEOUT_CYCLES     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    channel_lut_host_bridge_if.slave      wb,
    input  logic                          reset_comb_done,
    output logic [1:0]                    lut_WrRd,
    output logic [CHANNEL_INP_WIDTH-1:0]  lut_addr,
    output logic [CHANNEL_OUTP_WIDTH:0]   lut_dat_o,
    input  logic [CHANNEL_OUTP_WIDTH:0]   lut_dat_i,
    input  logic                          lut_ack
);

    typedef enum logic [1:0] {WAIT_INIT, IDLE, REQ, RESP} state_t;

    state_t state;
    logic   init_done;
    logic   init_seen;
    logic   host_dropped;
    logic   timeout_flag;
    logic   access;
    logic   status_sel;
    logic   unused_ok;
    logic [WB_DAT_WIDTH-1:0] status_word;

    assign access      = wb.wb_cyc_i & wb.wb_stb_i;
    assign status_sel  = wb.wb_adr_i[CHANNEL_INP_WIDTH];
    assign status_word = {{(WB_DAT_WIDTH-2){1'b0}}, timeout_flag, init_done};
    assign unused_ok   = &{1'b0, wb.wb_dat_i[WB_DAT_WIDTH-1:CHANNEL_OUTP_WIDTH+1]};

`ifdef CHANNEL_LUT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] timeout_cnt;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WAIT_INIT;
            wb.wb_ack_o  <= 1'b0;
            wb.wb_err_o  <= 1'b0;
            wb.wb_dat_o  <= '0;
            lut_WrRd     <= 2'b00;
            lut_addr     <= '0;
            lut_dat_o    <= '0;
            init_done    <= 1'b0;
            host_dropped <= 1'b0;
            // A clear-done pulse seen during reset must survive it.
            init_seen    <= init_seen | reset_comb_done;
`ifdef CHANNEL_LUT_TIMEOUT_EN
            timeout_flag <= 1'b0;
            timeout_cnt  <= '0;
`endif
        end else begin
            wb.wb_ack_o <= 1'b0;
            wb.wb_err_o <= 1'b0;
            if (reset_comb_done && !init_done)
                init_seen <= 1'b1;

            case (state)
                WAIT_INIT, IDLE: begin
                    if (state == WAIT_INIT && (init_seen || reset_comb_done)) begin
                        init_done <= 1'b1;
                        init_seen <= 1'b0;
                        state     <= IDLE;
                    end else if (access) begin
                        state <= RESP;
                        if (status_sel) begin
                            wb.wb_ack_o <= 1'b1;
                            wb.wb_dat_o <= status_word;
`ifdef CHANNEL_LUT_TIMEOUT_EN
                            if (wb.wb_we_i && wb.wb_dat_i[1])
                                timeout_flag <= 1'b0;
`endif
                        end else if (state == WAIT_INIT) begin
                            wb.wb_err_o <= 1'b1;
                        end else begin
                            lut_addr     <= wb.wb_adr_i[CHANNEL_INP_WIDTH-1:0];
                            if (wb.wb_we_i)
                                lut_dat_o <= wb.wb_dat_i[CHANNEL_OUTP_WIDTH:0];
                            lut_WrRd     <= {wb.wb_we_i, !wb.wb_we_i};
                            host_dropped <= 1'b0;
                            state        <= REQ;
`ifdef CHANNEL_LUT_TIMEOUT_EN
                            timeout_cnt  <= CNT_W'(TIMEOUT_CYCLES - 1);
`endif
                        end
                    end
                end

                REQ: begin
                    // The LUT operation always finishes; only the host response is dropped.
                    if (!wb.wb_cyc_i)
                        host_dropped <= 1'b1;
                    if (lut_ack) begin
                        lut_WrRd <= 2'b00;
                        if (lut_WrRd[0])
                            wb.wb_dat_o <= WB_DAT_WIDTH'(lut_dat_i);
                        wb.wb_ack_o <= wb.wb_cyc_i && !host_dropped;
                        state       <= RESP;
                    end
`ifdef CHANNEL_LUT_TIMEOUT_EN
                    else if (timeout_cnt == '0) begin
                        lut_WrRd     <= 2'b00;
                        timeout_flag <= 1'b1;
                        wb.wb_err_o  <= wb.wb_cyc_i && !host_dropped;
                        state        <= RESP;
                    end else begin
                        timeout_cnt <= timeout_cnt - 1'b1;
                    end
`endif
                end

                RESP: begin
                    state <= init_done ? IDLE : WAIT_INIT;
                end

                default: state <= WAIT_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_channel_lut_host_bridge.sv
// Directed self-checking bench for channel_lut_host_bridge; the bench plays both host and selector.
module tb_channel_lut_host_bridge;
    localparam int IW = 6;
    localparam int OW = 4;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam logic [IW:0] STATUS_ADR = 7'h40;

    logic clk = 1'b0;
    logic rst;
    logic reset_comb_done;
    logic lut_ack;
    logic [1:0]    lut_WrRd;
    logic [IW-1:0] lut_addr;
    logic [OW:0]   lut_dat_o;
    logic [OW:0]   lut_dat_i;
    logic [OW:0]   lut_mem [0:63];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    channel_lut_host_bridge_if #(.CHANNEL_INP_WIDTH(IW), .WB_DAT_WIDTH(DW)) bus ();

    channel_lut_host_bridge #(
        .CHANNEL_INP_WIDTH (IW),
        .CHANNEL_OUTP_WIDTH(OW),
        .WB_DAT_WIDTH      (DW),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wb             (bus),
        .reset_comb_done(reset_comb_done),
        .lut_WrRd       (lut_WrRd),
        .lut_addr       (lut_addr),
        .lut_dat_o      (lut_dat_o),
        .lut_dat_i      (lut_dat_i),
        .lut_ack        (lut_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic [IW:0] adr, input logic [31:0] dat, input logic we);
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_we_i  = we;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
    endtask

    task automatic idle_bus();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic status_rd(input string tag, input logic [31:0] exp);
        drive(STATUS_ADR, 32'h0, 1'b0);
        tick();
        chk({tag, "_ack"}, 32'(bus.wb_ack_o), 32'h1);
        chk({tag, "_dat"}, bus.wb_dat_o, exp);
        chk({tag, "_nolut"}, 32'(lut_WrRd), 32'h0);
        idle_bus();
        tick();
        chk({tag, "_ack_end"}, 32'(bus.wb_ack_o), 32'h0);
    endtask

    task automatic status_wr(input string tag, input logic [31:0] dat);
        drive(STATUS_ADR, dat, 1'b1);
        tick();
        chk({tag, "_ack"}, 32'(bus.wb_ack_o), 32'h1);
        idle_bus();
        tick();
    endtask

    // Full LUT access with the bench as selector: ack raised after E1, checked through E3.
    task automatic lut_xfer(input string tag, input logic [IW-1:0] adr, input logic [31:0] dat,
                            input logic we, input logic [31:0] exp_lut_dat, input logic [31:0] exp_rd);
        drive({1'b0, adr}, dat, we);
        tick();
        chk({tag, "_wrrd_e0"}, 32'(lut_WrRd), we ? 32'h2 : 32'h1);
        chk({tag, "_addr"}, 32'(lut_addr), 32'(adr));
        if (we) chk({tag, "_lutdat"}, 32'(lut_dat_o), exp_lut_dat);
        chk({tag, "_noack_e0"}, 32'(bus.wb_ack_o), 32'h0);
        tick();
        chk({tag, "_wrrd_e1"}, 32'(lut_WrRd), we ? 32'h2 : 32'h1);
        if (we) lut_mem[lut_addr] = lut_dat_o;
        else    lut_dat_i = lut_mem[lut_addr];
        lut_ack = 1'b1;
        tick();
        chk({tag, "_ack_e2"}, 32'(bus.wb_ack_o), 32'h1);
        chk({tag, "_noerr"}, 32'(bus.wb_err_o), 32'h0);
        chk({tag, "_wrrd_e2"}, 32'(lut_WrRd), 32'h0);
        if (!we) chk({tag, "_rddat"}, bus.wb_dat_o, exp_rd);
        lut_ack = 1'b0;
        idle_bus();
        tick();
        chk({tag, "_ack_e3"}, 32'(bus.wb_ack_o), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        reset_comb_done = 1'b0;
        lut_ack = 1'b0;
        lut_dat_i = '0;
        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;
        idle_bus();
        for (int i = 0; i < 64; i++) lut_mem[i] = '0;

        // Reset held 64 cycles with the clear-done pulse inside it.
        for (int i = 0; i < 64; i++) begin
            tick();
            reset_comb_done = (i == 20);
        end
        reset_comb_done = 1'b0;
        chk("rst_ack", 32'(bus.wb_ack_o), 32'h0);
        chk("rst_err", 32'(bus.wb_err_o), 32'h0);
        chk("rst_dat", bus.wb_dat_o, 32'h0);
        chk("rst_wrrd", 32'(lut_WrRd), 32'h0);
        chk("rst_addr", 32'(lut_addr), 32'h0);
        chk("rst_lutdat", 32'(lut_dat_o), 32'h0);
        rst = 1'b0;
        tick();
        status_rd("init_status", 32'h1);

        lut_xfer("wr_3e", 6'h3E, 32'h13, 1'b1, 32'h13, 32'h0);
        lut_xfer("rd_3e", 6'h3E, 32'h0, 1'b0, 32'h0, 32'h13);
        lut_xfer("wr_05", 6'h05, 32'hABCDE00A, 1'b1, 32'h0A, 32'h0);
        lut_xfer("rd_05", 6'h05, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0A);
        lut_xfer("rd_3e_again", 6'h3E, 32'h0, 1'b0, 32'h0, 32'h13);

        // Stray ack in IDLE.
        lut_ack = 1'b1;
        tick();
        lut_ack = 1'b0;
        chk("stray_wrrd", 32'(lut_WrRd), 32'h0);
        chk("stray_ack", 32'(bus.wb_ack_o), 32'h0);
        tick();
        chk("stray_ack2", 32'(bus.wb_ack_o), 32'h0);

        status_wr("st_wr2", 32'h2);
        status_rd("st_after_wr2", 32'h1);

`ifdef CHANNEL_LUT_TIMEOUT_EN
        // Silent selector: error after 16 cycles in REQ.
        drive(7'h01, 32'h5, 1'b1);
        tick();
        chk("to_wrrd_e0", 32'(lut_WrRd), 32'h2);
        for (int k = 1; k < TO; k++) begin
            tick();
            chk("to_wait_err", 32'(bus.wb_err_o), 32'h0);
            chk("to_wait_wrrd", 32'(lut_WrRd), 32'h2);
        end
        tick();
        chk("to_err", 32'(bus.wb_err_o), 32'h1);
        chk("to_noack", 32'(bus.wb_ack_o), 32'h0);
        chk("to_wrrd_clr", 32'(lut_WrRd), 32'h0);
        idle_bus();
        tick();
        chk("to_err_end", 32'(bus.wb_err_o), 32'h0);
        status_rd("to_status", 32'h3);
        status_wr("to_clear", 32'h2);
        status_rd("to_status_clr", 32'h1);
`endif

        // Host drops cyc during REQ: LUT op completes, no host response.
        drive(7'h10, 32'h1F, 1'b1);
        tick();
        chk("drop_wrrd_e0", 32'(lut_WrRd), 32'h2);
        idle_bus();
        tick();
        chk("drop_wrrd_e1", 32'(lut_WrRd), 32'h2);
        lut_ack = 1'b1;
        tick();
        chk("drop_noack", 32'(bus.wb_ack_o), 32'h0);
        chk("drop_noerr", 32'(bus.wb_err_o), 32'h0);
        chk("drop_wrrd_e2", 32'(lut_WrRd), 32'h0);
        lut_ack = 1'b0;
        tick();
        chk("drop_noack_e3", 32'(bus.wb_ack_o), 32'h0);
        status_rd("drop_status", 32'h1);

        // Reset during REQ.
        drive(7'h20, 32'h7, 1'b1);
        tick();
        chk("mid_wrrd_e0", 32'(lut_WrRd), 32'h2);
        rst = 1'b1;
        tick();
        chk("mid_wrrd", 32'(lut_WrRd), 32'h0);
        chk("mid_noack", 32'(bus.wb_ack_o), 32'h0);
        chk("mid_addr", 32'(lut_addr), 32'h0);
        chk("mid_lutdat", 32'(lut_dat_o), 32'h0);
        rst = 1'b0;
        idle_bus();
        tick();
        tick();
        chk("mid_noack2", 32'(bus.wb_ack_o), 32'h0);
        status_rd("uninit_status", 32'h0);

        // LUT access before clear-done: error, no LUT request.
        drive(7'h01, 32'h0, 1'b0);
        tick();
        chk("uninit_err", 32'(bus.wb_err_o), 32'h1);
        chk("uninit_noack", 32'(bus.wb_ack_o), 32'h0);
        chk("uninit_wrrd", 32'(lut_WrRd), 32'h0);
        idle_bus();
        tick();
        chk("uninit_err_end", 32'(bus.wb_err_o), 32'h0);
        chk("uninit_wrrd2", 32'(lut_WrRd), 32'h0);
        status_rd("still_uninit", 32'h0);

        reset_comb_done = 1'b1;
        tick();
        reset_comb_done = 1'b0;
        status_rd("reinit_status", 32'h1);
        lut_xfer("wr_01", 6'h01, 32'h11, 1'b1, 32'h11, 32'h0);
        lut_xfer("rd_01", 6'h01, 32'h0, 1'b0, 32'h0, 32'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
